// File: rtl/positadd_arbiter_if.sv
// Bundles the requester-side and adder-side signals of positadd_arbiter.
// master: the arbiter itself; slave: requesters, adder and result consumer.
interface positadd_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Requester i transfers an operand pair in a cycle where req_valid[i] and
    // req_ready[i] are both high; a requester keeps req_valid and its operands
    // stable until that happens. Results are pushed with res_valid and cannot
    // be back-pressured.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;

    logic [31:0]        add_in1;
    logic [31:0]        add_in2;
    logic               add_start;
    logic [31:0]        add_result;
    logic               add_inf;
    logic               add_zero;
    logic               add_done;

    logic               res_valid;
    logic [TAGW-1:0]    res_tag;
    logic [31:0]        res_data;
    logic               res_inf;
    logic               res_zero;

    modport master (
        input  req_valid, req_a, req_b, add_result, add_inf, add_zero, add_done,
        output req_ready, add_in1, add_in2, add_start,
               res_valid, res_tag, res_data, res_inf, res_zero
    );

    modport slave (
        output req_valid, req_a, req_b, add_result, add_inf, add_zero, add_done,
        input  req_ready, add_in1, add_in2, add_start,
               res_valid, res_tag, res_data, res_inf, res_zero
    );
endinterface

// File: rtl/positadd_arbiter.sv
// Round-robin arbiter sharing one pipelined positadd_4 among NREQ requesters.
// Define POSITADD_ARB_STATS_EN to add the stat_issued / stat_stall counters.
module positadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    positadd_arbiter_if.master     bus,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   busy,
    output logic                   err_sync,
    output logic [1:0]             dbg_state
`ifdef POSITADD_ARB_STATS_EN
    ,
    output logic [31:0]            stat_issued,
    output logic [31:0]            stat_stall
`endif
);

    localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    state_t              state;
    logic [TAGW-1:0]     ptr;
    logic                grant_en;
    logic                gnt_any;
    logic [TAGW-1:0]     gnt_idx;
    logic [LATENCY-1:0]  pipe_vld;
    logic [TAGW-1:0]     pipe_tag [LATENCY];
    logic                last_vld;
    logic                retire;
    logic [CNTW-1:0]     count;
    logic [CNTW-1:0]     count_nxt;
    logic [CNTW-1:0]     settle;

    // Gated by rst_n so nothing is offered to requesters while reset is held.
    assign grant_en = (state == RUN) && rst_n;

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (grant_en) begin
            for (int off = 0; off < NREQ; off++) begin
                j = int'(ptr) + off;
                if (j >= NREQ) j = j - NREQ;
                if (!gnt_any && bus.req_valid[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = TAGW'(j);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.add_start = gnt_any;
        bus.add_in1   = '0;
        bus.add_in2   = '0;
        if (gnt_any) begin
            bus.req_ready[gnt_idx] = 1'b1;
            bus.add_in1 = bus.req_a[{gnt_idx, 5'd0} +: 32];
            bus.add_in2 = bus.req_b[{gnt_idx, 5'd0} +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
        end
    end

    // Tag pipe mirrors the adder pipeline so each add_done can be matched
    // to the requester that issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= gnt_any;
            pipe_tag[0] <= gnt_idx;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign last_vld      = pipe_vld[LATENCY-1];
    assign retire        = last_vld & bus.add_done;
    assign bus.res_valid = retire;
    assign bus.res_tag   = retire ? pipe_tag[LATENCY-1] : '0;
    assign bus.res_data  = retire ? bus.add_result : '0;
    assign bus.res_inf   = retire & bus.add_inf;
    assign bus.res_zero  = retire & bus.add_zero;

    always_comb begin
        count_nxt = count;
        if (gnt_any && !retire)      count_nxt = count + CNTW'(1);
        else if (!gnt_any && retire) count_nxt = count - CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt;
    end

    assign busy = (count != '0);

    // Looking at count_nxt lets flush_done rise the cycle after the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) state <= DRAIN;
                end
                DRAIN: begin
                    if (count_nxt == '0) begin
                        state      <= FLUSHED;
                        flush_done <= 1'b1;
                    end
                end
                FLUSHED: begin
                    if (!flush) begin
                        state      <= RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // The adder is not reset, so its stages may still emit done pulses
    // for a while after reset; the settle window hides those from err_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle   <= CNTW'(LATENCY);
            err_sync <= 1'b0;
        end else if (settle != '0) begin
            settle <= settle - CNTW'(1);
        end else if (last_vld != bus.add_done) begin
            err_sync <= 1'b1;
        end
    end

`ifdef POSITADD_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (gnt_any && (stat_issued != '1))
                stat_issued <= stat_issued + 32'd1;
            if ((bus.req_valid != '0) && !gnt_any && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_positadd_arbiter.sv
// Directed bench for positadd_arbiter with a behavioural fixed-latency adder.
module tb_positadd_arbiter;

  localparam int NREQ = 4;
  localparam int L    = 4;
  localparam int TAGW = 2;
  localparam int EW   = TAGW + 34;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       flush_done;
  logic       busy;
  logic       err_sync;
  logic [1:0] dbg_state;
`ifdef POSITADD_ARB_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  positadd_arbiter_if #(.NREQ(NREQ)) bus ();

  positadd_arbiter #(.NREQ(NREQ), .LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .err_sync   (err_sync),
    .dbg_state  (dbg_state)
`ifdef POSITADD_ARB_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  // ---------------- operands ----------------
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign bus.req_a[32*g +: 32] = op_a[g];
    assign bus.req_b[32*g +: 32] = op_b[g];
  end

  // Stand-in for positadd_4: 1.0 + 1.0 gives 2.0, everything else a token sum.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return a + b;
  endfunction

  // ---------------- adder model (never reset) ----------------
  logic [L-1:0]    apipe_v = '0;
  logic [L*32-1:0] apipe_d = '0;
  logic            force_done = 1'b0;
  always @(posedge clk) begin
    apipe_v <= {apipe_v[L-2:0], bus.add_start};
    apipe_d <= {apipe_d[(L-1)*32-1:0], model_add(bus.add_in1, bus.add_in2)};
  end
  assign bus.add_done   = apipe_v[L-1] | force_done;
  assign bus.add_result = apipe_d[L*32-1 -: 32];
  assign bus.add_inf    = (bus.add_result == 32'h8000_0000);
  assign bus.add_zero   = (bus.add_result == 32'h0);

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic          mon_exp_v;
  logic [EW-1:0] mon_e;
  initial forever begin
    @(negedge clk);
    #2;
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      errors++;
      $display("FAIL res_missing: got no result expected one (cycle %0d)", cyc);
    end
    mon_exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("res_valid", bus.res_valid, mon_exp_v);
    if (mon_exp_v) begin
      mon_e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("res_tag",  bus.res_tag,  mon_e[32 +: TAGW]);
      chk("res_data", bus.res_data, mon_e[31:0]);
      chk("res_inf",  bus.res_inf,  mon_e[EW-2]);
      chk("res_zero", bus.res_zero, mon_e[EW-1]);
    end else begin
      chk("res_idle", {bus.res_tag, bus.res_data, bus.res_inf, bus.res_zero}, 64'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [NREQ-1:0] v, input logic fl,
                       input logic [NREQ-1:0] exp_rdy, input string name);
    int          idx;
    logic [31:0] r;
    idx = 0;
    @(negedge clk);
    bus.req_valid = v;
    flush         = fl;
    #1;
    for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) idx = i;
    chk({name, " req_ready"}, bus.req_ready, exp_rdy);
    chk({name, " add_start"}, bus.add_start, exp_rdy != '0);
    chk({name, " add_in1"}, bus.add_in1, (exp_rdy != '0) ? op_a[idx] : 32'h0);
    chk({name, " add_in2"}, bus.add_in2, (exp_rdy != '0) ? op_b[idx] : 32'h0);
    if (exp_rdy != '0) begin
      r = model_add(op_a[idx], op_b[idx]);
      exp_q.push_back({r == 32'h0, r == 32'h8000_0000, TAGW'(idx), r});
      due_q.push_back(cyc + L);
    end
  endtask

  task automatic final_report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_ready;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    final_report();
  end

  // ---------------- test ----------------
  initial begin
    // Consecutive cycles starting with ptr = 3.
    tbl[0]  = '{4'b1111, 4'b1000};
    tbl[1]  = '{4'b1111, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b1000};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b1010, 4'b0010};
    tbl[7]  = '{4'b1010, 4'b1000};
    tbl[8]  = '{4'b1010, 4'b0010};
    tbl[9]  = '{4'b1010, 4'b1000};
    tbl[10] = '{4'b1010, 4'b0010};
    tbl[11] = '{4'b0101, 4'b0100};
    tbl[12] = '{4'b0001, 4'b0001};
    tbl[13] = '{4'b1001, 4'b1000};
    tbl[14] = '{4'b0110, 4'b0010};
    tbl[15] = '{4'b1111, 4'b0100};

    op_a[0] = 32'h0000_0000; op_b[0] = 32'h0000_0000;
    op_a[1] = 32'h0100_0001; op_b[1] = 32'h0000_0022;
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4000_0000;
    op_a[3] = 32'h8000_0000; op_b[3] = 32'h0000_0000;

    // Reset with every requester asking: nothing may be granted.
    bus.req_valid = '1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst add_start", bus.add_start, 0);
    chk("rst busy", busy, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst err_sync", err_sync, 0);
    chk("rst state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Single request from requester 2: 1.0 + 1.0.
    drive(4'b0100, 1'b0, 4'b0100, "single");
    drive(4'b0000, 1'b0, 4'b0000, "idle");
    chk("busy inflight", busy, 1);
    repeat (L) drive(4'b0000, 1'b0, 4'b0000, "idle");

    for (int i = 0; i < 16; i++) drive(tbl[i].valid, 1'b0, tbl[i].exp_ready, "tbl");
    repeat (L + 1) drive(4'b0000, 1'b0, 4'b0000, "drain");
    chk("busy drained", busy, 0);
    chk("err_sync clean", err_sync, 0);

    // Three issues then flush; requests held during drain must not be granted.
    drive(4'b0111, 1'b0, 4'b0001, "fl_issue");
    drive(4'b0111, 1'b0, 4'b0010, "fl_issue");
    drive(4'b0111, 1'b0, 4'b0100, "fl_issue");
    drive(4'b0000, 1'b1, 4'b0000, "fl_assert");
    for (int k = 2; k <= L + 2; k++) begin
      drive(4'b0111, 1'b1, 4'b0000, "fl_hold");
      chk("fl flush_done", flush_done, k >= L + 1);
      chk("fl state", dbg_state, (k >= L + 1) ? 2'd2 : 2'd1);
    end
    chk("fl busy", busy, 0);
    drive(4'b0111, 1'b0, 4'b0000, "fl_release");
    chk("fl release flush_done", flush_done, 1);
    drive(4'b0111, 1'b0, 4'b0001, "fl_resume");
    chk("fl resume flush_done", flush_done, 0);

    // Flush raised alongside a pending request: that grant still happens.
    drive(4'b0100, 1'b1, 4'b0100, "fl_same");
    for (int k = 1; k <= L + 1; k++) begin
      drive(4'b0000, 1'b1, 4'b0000, "fl_same_hold");
      chk("fl_same flush_done", flush_done, k >= L + 1);
    end
    drive(4'b0000, 1'b0, 4'b0000, "fl_same_release");
    drive(4'b0000, 1'b0, 4'b0000, "idle");

    // Reset with two operations in flight; their results must vanish.
    drive(4'b0011, 1'b0, 4'b0001, "rst_issue");
    drive(4'b0011, 1'b0, 4'b0010, "rst_issue");
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    exp_q.delete();
    due_q.delete();
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 3) drive(4'b0000, 1'b0, 4'b0000, "post_rst");
    chk("post_rst err_sync", err_sync, 0);
    chk("post_rst busy", busy, 0);
    drive(4'b1111, 1'b0, 4'b0001, "post_rst_ptr");
    repeat (L + 1) drive(4'b0000, 1'b0, 4'b0000, "drain");

    // Stray add_done with an empty pipe sets err_sync until reset.
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    #1;
    chk("err_sync set", err_sync, 1);
    repeat (5) drive(4'b0000, 1'b0, 4'b0000, "idle");
    chk("err_sync sticky", err_sync, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("err_sync rst", err_sync, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 2) drive(4'b0000, 1'b0, 4'b0000, "idle");
    chk("err_sync after rst", err_sync, 0);

    chk("queue empty", exp_q.size(), 0);
    final_report();
  end

endmodule

// File: doc/positadd_arbiter.md
POSITADD_ARBITER -- requirements
Module: positadd_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one positadd_4 instance, range 2..8.
REQ-002 Parameter LATENCY, default 4: cycles from add_start sampled to add_done asserted; matches positadd_4.
REQ-003 Localparam TAGW = max(1, clog2(NREQ)): requester index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operand pair valid.
REQ-007 req_ready  out  NREQ  per-requester grant; one-hot or zero.
REQ-008 req_a, req_b  in  NREQ*32  posit operands; requester i occupies bits [32i+31:32i].
REQ-009 add_in1, add_in2  out  32  operands to adder.
REQ-010 add_start  out  1  issue strobe to adder.
REQ-011 add_result  in  32; add_inf, add_zero, add_done  in  1 each  adder outputs.
REQ-012 res_valid  out  1; res_tag  out  TAGW; res_data  out  32; res_inf, res_zero  out  1  routed result, no backpressure.
REQ-013 flush  in  1  level request to stop issuing and drain.
REQ-014 flush_done  out  1; busy  out  1; err_sync  out  1  sticky tag/done misalignment flag.

Function
REQ-015 req_ready, add_in1/add_in2/add_start are combinational from req_valid, rr pointer and state; adder registers its own inputs.
REQ-016 Round-robin: grant lowest index i >= ptr with req_valid[i], wrapping to 0; ptr <= (granted+1) mod NREQ on grant, else holds.
REQ-017 At most one grant per cycle; transfer on req_valid[i] & req_ready[i]; add_start = |(req_valid & req_ready); add_in1/add_in2 = granted operands, else 0.
REQ-018 Tag pipe: LATENCY-deep shift register of {valid, tag}; stage 0 loaded each cycle with {add_start, granted index}.
REQ-019 res_valid = last pipe stage valid & add_done; res_tag = last stage tag; res_data/res_inf/res_zero = adder outputs; all zero when res_valid low.
REQ-020 Throughput one issue per cycle; issue-to-res_valid latency exactly LATENCY cycles.
REQ-021 In-flight counter 0..LATENCY: +1 on issue, -1 on res_valid, unchanged when both; busy = (count != 0).
REQ-022 FSM RUN: grants enabled; flush=1 -> DRAIN.
REQ-023 FSM DRAIN: req_ready all zero; count==0 -> FLUSHED.
REQ-024 FSM FLUSHED: flush_done=1, no grants; flush=0 -> RUN; flush still 1 -> stay.
REQ-025 flush asserted in same cycle as a pending request: that cycle's grant still occurs (decision uses registered state RUN).
REQ-026 err_sync set when last stage valid != add_done, except during the LATENCY cycles after reset release; cleared only by reset.
REQ-027 Requesters holding req_valid keep operands stable until granted; non-granted requesters never lose their request.

Reset
REQ-028 On rst_n low: ptr=0, state=RUN, tag pipe cleared, count=0, err_sync=0, res_*=0, flush_done=0, busy=0, req_ready=0, add_start=0.
REQ-029 Reset mid-operation discards in-flight results; stray add_done from unreset adder stages never produces res_valid.
REQ-030 Post-reset settle counter (LATENCY cycles) masks err_sync.

Configuration
REQ-031 Macro POSITADD_ARB_STATS_EN defined: add outputs stat_issued (32) and stat_stall (32), counting issues and cycles with req_valid!=0 and no grant; reset 0, saturating at all-ones.
REQ-032 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-033 Single req_valid[2]=1, a=0x40000000, b=0x40000000 -> req_ready[2] same cycle, res_valid 4 cycles later, res_tag=2, res_data=0x48000000.
REQ-034 All four valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; res_tag sequence identical, delayed 4.
REQ-035 Requesters 1 and 3 valid, ptr=2 -> grant 3 then 1; ptr ends at 2.
REQ-036 Issue 3 ops, flush=1 next cycle -> req_ready=0, flush_done=1 the cycle after third res_valid; flush=0 -> grants resume.
REQ-037 rst_n low for 1 cycle with 2 ops in flight -> no res_valid afterwards, err_sync=0, busy=0.
REQ-038 Force add_done=1 with empty pipe after settle -> err_sync=1, held until reset.
